uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  - Fast-domain serial input stage for the ',' (input) instruction.
//  - Deserialises 8N1 UART frames on clk into a byte plus a 1-cycle dataValid strobe.
//  - dataValid drives the fast-side `in` of the pulse catcher, which widens it for the slow CPU clock.
//  - data is held stable until the next good frame, so the slow domain can read it at leisure.
// PARAMETERS
//  - CLKS_PER_BIT  868  clk cycles per bit period (100 MHz / 115200); legal range 4..65535
//  - PARITY_ODD    0    used only with UART_PARITY_EN: 0 = even parity, 1 = odd parity
// PORTS
//  - clk          in   1  single clock; all logic is on its rising edge
//  - reset        in   1  asynchronous, active-low reset
//  - rx           in   1  asynchronous serial line; idles high
//  - data         out  8  last good byte; LSB is received first
//  - dataValid    out  1  1-cycle pulse when data is updated
//  - frameError   out  1  1-cycle pulse when the stop bit is sampled low
//  - busy         out  1  high from confirmed start bit until return to IDLE
//  - parityError  out  1  present only with UART_PARITY_EN; 1-cycle pulse
// BEHAVIOUR
//  - Reset: applies while reset==0, with no clock needed.
//    - Outputs: data=0, dataValid=0, frameError=0, busy=0, parityError=0.
//    - Internal: sync flops=1, state=IDLE, counters=0.
//    - Reset mid-frame abandons the frame; nothing is emitted for it.
//  - Synchroniser: rx passes through 2 flops (rxs).
//    - All sampling uses rxs, so there is 2 clk of input latency.
//  - Counters:
//    - Baud counter width = $clog2(CLKS_PER_BIT); bit index is 3 bits.
//    - Every compare is against CLKS_PER_BIT-1 or (CLKS_PER_BIT/2)-1, so there is no overflow wrap.
//  - FSM:
//    - IDLE: rxs==0 -> START, clear the baud counter.
//    - START: wait CLKS_PER_BIT/2 clk (mid-bit).
//      - rxs==1: false start (glitch) -> IDLE, no outputs.
//      - rxs==0: busy=1, go to DATA, counter restarts.
//    - DATA: sample rxs every CLKS_PER_BIT clk into shift[idx], idx 0..7.
//      - After idx 7 -> STOP (or PARITY with the macro).
//    - STOP: sample after CLKS_PER_BIT clk.
//      - rxs==1: next clk data<=shift, dataValid=1 -> IDLE.
//      - rxs==0: next clk frameError=1, data unchanged -> BREAK.
//    - BREAK: hold until rxs==1, then -> IDLE. A long low line gives exactly one frameError.
//  - Timing:
//    - Latency: dataValid rises 1 clk after the stop-bit mid-sample.
//    - That is about 9.5 bit periods + 3 clk after the rx falling edge.
//  - Back-to-back frames: IDLE is re-entered at the stop-bit midpoint.
//    - A start edge arriving during the second half of the stop bit is caught. No gap is required.
//  - Pulse rules:
//    - dataValid and frameError are never high together.
//    - The pulses are never wider than 1 clk.
//  - busy falls in the same cycle that dataValid or frameError is asserted.
//  - No overrun detection: a new good frame overwrites data.
// CONFIGURATION
//  - Macro UART_PARITY_EN.
//  - Defined:
//    - PARITY state between DATA and STOP samples a 9th bit.
//    - Expected bit = ^shift ^ PARITY_ODD.
//    - On mismatch with a good stop bit: parityError pulses, data stays unchanged, no dataValid.
//    - A stop-bit error takes priority: frameError only.
//    - The parityError port exists.
//  - Undefined: 8N1 only; there is no PARITY state, no parityError port, and PARITY_ODD is ignored.
// TESTING
//  - Bench uses CLKS_PER_BIT=16.
//  - T1: send 0x2C, 8N1.
//    - data==0x2C; dataValid is high for exactly 1 clk, 155+/-2 clk after the start edge.
//    - busy is high in between.
//  - T2: 3-clk low glitch on idle rx.
//    - No dataValid, no frameError; busy stays 0; state returns to IDLE.
//  - T3: send 0xA5 with stop bit low, then hold rx low for 40 bit times.
//    - Exactly one frameError; data keeps its previous value.
//    - A following 0x5A is received correctly.
//  - T4: 0x00, 0xFF, 0x41 back-to-back with no idle gap.
//    - Three dataValid pulses with data 0x00, 0xFF, 0x41 in order.
//  - T5: drop reset at bit 4 of a frame, then release.
//    - All outputs are 0 immediately, with no clk edge.
//    - The next full frame 0x33 is received.
//  - T6 (UART_PARITY_EN, PARITY_ODD=0):
//    - 0x07 with parity bit 1 -> dataValid, data==0x07.
//    - 0x07 with parity bit 0 -> parityError pulse; data unchanged.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial deserialiser, optional parity via UART_PARITY_EN.
// Emits a byte plus 1-cycle dataValid, frameError and (optional) parityError.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dataValid,
  output logic       frameError,
  output logic       busy
`ifdef UART_PARITY_EN
  ,
  output logic       parityError
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_n;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          dv_n, fe_n, busy_n;

`ifdef UART_PARITY_EN
  logic pbad, pbad_n, pe_n;
`else
  // PARITY_ODD only matters when parity is compiled in
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // two-flop synchroniser; line idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data       <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_PARITY_EN
      pbad        <= 1'b0;
      parityError <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      data       <= data_n;
      dataValid  <= dv_n;
      frameError <= fe_n;
      busy       <= busy_n;
`ifdef UART_PARITY_EN
      pbad        <= pbad_n;
      parityError <= pe_n;
`endif
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    busy_n  = busy;
`ifdef UART_PARITY_EN
    pbad_n  = pbad;
    pe_n    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            busy_n  = 1'b1;
            idx_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt == LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rxs;
          if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          pbad_n  = rxs != (^shift ^ PARITY_ODD);
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == LAST) begin
          cnt_n  = '0;
          busy_n = 1'b0;
          if (rxs) begin
            state_n = S_IDLE;
`ifdef UART_PARITY_EN
            if (pbad) begin
              pe_n = 1'b1;
            end else begin
              data_n = shift;
              dv_n   = 1'b1;
            end
`else
            data_n = shift;
            dv_n   = 1'b1;
`endif
          end else begin
            fe_n    = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver at 16 clk per bit.
// Covers framing, glitch reject, break, back-to-back, async reset, parity.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       dv, fe, busy;
`ifdef UART_PARITY_EN
  logic       pe;
`endif

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0, last_dv = 0;
  int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, busy_cyc = 0;
  int wide = 0, both = 0;
  int d0, f0, b0, p0;
  logic dv_prev = 1'b0, fe_prev = 1'b0;
  logic [7:0] dq[$];

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .dataValid  (dv),
    .frameError (fe),
    .busy       (busy)
`ifdef UART_PARITY_EN
    ,
    .parityError(pe)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (dv) begin
      dv_cnt++;
      last_dv = cyc;
      dq.push_back(data);
    end
    if (fe) fe_cnt++;
`ifdef UART_PARITY_EN
    if (pe) pe_cnt++;
`endif
    if (busy) busy_cyc++;
    if (dv && fe) both++;
    if ((dv && dv_prev) || (fe && fe_prev)) wide++;
    dv_prev = dv;
    fe_prev = fe;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input bit use_par, input logic par_v);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (use_par) send_bit(par_v);
    send_bit(stop_v);
  endtask

  initial begin
    // reset, no clock edge yet
    #2 reset = 1'b0;
    #1;
    check("rst_data", data, 0);
    check("rst_dv", dv, 0);
    check("rst_fe", fe, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;

    // T1: single frame, latency and busy window
    d0 = dv_cnt;
    busy_cyc = 0;
    send_frame(8'h2C, 1'b1, 1'b0, 1'b0);
    check("t1_count", dv_cnt - d0, 1);
    check("t1_data", data, 8'h2C);
    check("t1_latency", last_dv - start_cyc, 155);
    check("t1_busy_cycles", busy_cyc, 144);
    check("t1_busy_end", busy, 0);

    // T2: 3-clk glitch is rejected
    d0 = dv_cnt; f0 = fe_cnt; b0 = busy_cyc;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("t2_dv", dv_cnt - d0, 0);
    check("t2_fe", fe_cnt - f0, 0);
    check("t2_busy", busy_cyc - b0, 0);

    // T3: bad stop bit then a long break, then recovery
    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (40 * CPB) @(posedge clk);
    #1;
    check("t3_fe", fe_cnt - f0, 1);
    check("t3_dv", dv_cnt - d0, 0);
    check("t3_data_kept", data, 8'h2C);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check("t3_fe_after", fe_cnt - f0, 1);
    check("t3_dv_after", dv_cnt - d0, 1);
    check("t3_data_5a", data, 8'h5A);

    // T4: back-to-back frames, no idle gap
    dq.delete();
    d0 = dv_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    check("t4_count", dv_cnt - d0, 3);
    check("t4_qsize", dq.size(), 3);
    if (dq.size() == 3) begin
      check("t4_b0", dq[0], 8'h00);
      check("t4_b1", dq[1], 8'hFF);
      check("t4_b2", dq[2], 8'h41);
    end

    // T5: async reset in the middle of bit 4
    d0 = dv_cnt; f0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    check("t5_busy_pre", busy, 1);
    check("t5_data_pre", data, 8'h41);
    reset = 1'b0;
    #1;
    check("t5_rst_data", data, 0);
    check("t5_rst_dv", dv, 0);
    check("t5_rst_fe", fe, 0);
    check("t5_rst_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    check("t5_dv", dv_cnt - d0, 1);
    check("t5_fe", fe_cnt - f0, 0);
    check("t5_data", data, 8'h33);

`ifdef UART_PARITY_EN
    // T6: even parity, bad parity first, then good
    d0 = dv_cnt; p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("t6_pe", pe_cnt - p0, 1);
    check("t6_bad_dv", dv_cnt - d0, 0);
    check("t6_data_kept", data, 8'h33);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("t6_good_dv", dv_cnt - d0, 1);
    check("t6_pe_after", pe_cnt - p0, 1);
    check("t6_data", data, 8'h07);
`endif

    check("no_overlap", both, 0);
    check("pulse_width", wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
